branch_resolve_queue: RTL

- Sits directly downstream of predictor_top.
- Captures each issued prediction (table index plus predicted direction) in order, then pairs it with the branch outcome when it resolves several cycles later.
- Emits a registered update record (index, actual outcome, mispredict flag) that drives the predictor's table training and success accounting.
- Keeps saturating accuracy counters for the bench and for performance reporting.

---
 rtl/branch_resolve_queue_if.sv | 37 +++
 rtl/branch_resolve_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// Handshake/update bundle between the prediction source, the resolution logic
// and branch_resolve_queue. The master drives predictions and resolutions; the slave is the queue.
interface branch_resolve_queue_if #(
    parameter int INDEX_W = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               pred_valid;
    logic [INDEX_W-1:0] pred_index;
    logic               prediction;
    logic               pred_ready;
    logic               resolve_valid;
    logic               branch_outcome;
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_index;
    logic               upd_outcome;
    logic               mispredict;
    logic               resolve_err;
    logic [COUNT_W-1:0] count;
    logic [CNT_W-1:0]   total_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    modport master (
        output flush, pred_valid, pred_index, prediction, resolve_valid, branch_outcome,
        input  pred_ready, upd_valid, upd_index, upd_outcome, mispredict, resolve_err,
               count, total_cnt, miss_cnt
    );

    modport slave (
        input  flush, pred_valid, pred_index, prediction, resolve_valid, branch_outcome,
        output pred_ready, upd_valid, upd_index, upd_outcome, mispredict, resolve_err,
               count, total_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue pairing issued predictions with resolved outcomes and emitting a
// registered training record. Accuracy counters are built only when BRQ_STATS_EN is defined.
module branch_resolve_queue #(
    parameter int INDEX_W = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

    logic [INDEX_W-1:0] idx_mem_q [DEPTH];
    logic [DEPTH-1:0]   pred_mem_q;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               upd_valid_q, upd_valid_d;
    logic [INDEX_W-1:0] upd_index_q, upd_index_d;
    logic               upd_outcome_q, upd_outcome_d;
    logic               mispredict_q, mispredict_d;
    logic               resolve_err_q, resolve_err_d;
    logic               push, pop;

    always_comb begin
        // Ready comes from the registered count, so a same-cycle pop never frees a slot.
        push          = bus.pred_valid && (count_q != FULL) && !bus.flush;
        pop           = bus.resolve_valid && (count_q != '0);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        upd_valid_d   = pop;
        upd_index_d   = upd_index_q;
        upd_outcome_d = upd_outcome_q;
        mispredict_d  = mispredict_q;
        resolve_err_d = bus.resolve_valid && (count_q == '0);

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
        end

        // A popped branch is reported even when flushed: it really did resolve.
        if (pop) begin
            upd_index_d   = idx_mem_q[rd_ptr_q];
            upd_outcome_d = bus.branch_outcome;
            mispredict_d  = pred_mem_q[rd_ptr_q] ^ bus.branch_outcome;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_index_q   <= '0;
            upd_outcome_q <= 1'b0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_index_q   <= upd_index_d;
            upd_outcome_q <= upd_outcome_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem_q[wr_ptr_q]  <= bus.pred_index;
            pred_mem_q[wr_ptr_q] <= bus.prediction;
        end
    end

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        total_d = sat_inc(total_q, pop);
        miss_d  = sat_inc(miss_q, pop && mispredict_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            miss_q  <= '0;
        end else begin
            total_q <= total_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.total_cnt = total_q;
    assign bus.miss_cnt  = miss_q;
`else
    assign bus.total_cnt = '0;
    assign bus.miss_cnt  = '0;
`endif

    assign bus.pred_ready  = (count_q != FULL);
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_index   = upd_index_q;
    assign bus.upd_outcome = upd_outcome_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.resolve_err = resolve_err_q;
    assign bus.count       = count_q;
endmodule
